pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage ARM pipeline. It combines the hazard-detection request, the EX-stage taken-branch signal and a fixed-latency data-memory wait into per-stage freeze/flush controls. It drives the PC register, the IF stage register (freeze/flush), the ID/EX flush, and a common freeze for ID/EX, EX/MEM and MEM/WB. It also keeps a saturating count of stall cycles for performance debug.

Parameters:
MEM_LATENCY, 3, total cycles a load/store occupies the MEM stage (legal 1..255); 1 = no memory stall.
STALL_CNT_W, 16, width of stall_count.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
hazard  input  1  data hazard from hazard detection unit (combinational, same cycle)
branch_taken  input  1  taken branch resolved in EX stage
mem_r_en  input  1  load in MEM stage (from EX/MEM register)
mem_w_en  input  1  store in MEM stage (from EX/MEM register)
pc_freeze  output  1  hold PC register
if_freeze  output  1  freeze to IF stage register
if_flush  output  1  flush to IF stage register (insert NOP)
id_flush  output  1  flush ID/EX register (bubble)
stage_freeze  output  1  freeze ID/EX, EX/MEM, MEM/WB registers
mem_busy  output  1  multi-cycle memory access in progress
stall_count  output  STALL_CNT_W  saturating count of cycles with pc_freeze=1

Behaviour:
- FSM states: IDLE, WAIT, DONE; down-counter cnt[7:0].
- mem_access = mem_r_en | mem_w_en.
- mem_stall (combinational) = (state==IDLE & mem_access & MEM_LATENCY>1) | (state==WAIT).
- IDLE: if mem_access and MEM_LATENCY>=3 -> WAIT, cnt<=MEM_LATENCY-3; if mem_access and MEM_LATENCY==2 -> DONE; otherwise stay in IDLE.
- WAIT: cnt==0 -> DONE; else cnt<=cnt-1.
- DONE: mem_stall=0, so the pipeline advances; -> IDLE unconditionally. mem_access is ignored in DONE (same instruction leaving).
- Result: mem_stall is high for exactly MEM_LATENCY-1 consecutive cycles per access. Back-to-back loads each incur the full stall, separated by one DONE cycle.
- mem_busy = mem_stall.
- stage_freeze = mem_stall.
- pc_freeze = if_freeze = mem_stall | (hazard & ~branch_taken).
- if_flush = branch_taken & ~mem_stall.
- id_flush = (branch_taken | hazard) & ~mem_stall.
- Priority:
  - mem_stall overrides everything; no flush is issued during a stall.
  - branch_taken stays asserted because EX is frozen, so the flush is issued in the first unstalled cycle (the DONE cycle).
  - A branch overrides a hazard: the PC is not frozen, so the branch target is loaded.
- stall_count increments by 1 every cycle pc_freeze=1 and saturates at all-ones (no wrap).
- Reset: rst=1 at an edge sets state=IDLE, cnt=0, stall_count=0. While rst=1, all control outputs are forced to 0 combinationally. Reset during WAIT aborts the access; the next cycle is IDLE.
- No latency on the control outputs: they are combinational from inputs and the registered state.

Test Plan:
- Reset: rst=1 for 2 cycles with hazard=1, mem_r_en=1 -> all outputs 0; after release, state IDLE, stall_count=0.
- Load, MEM_LATENCY=3: mem_r_en=1 held 3 cycles -> stage_freeze/pc_freeze=1 for exactly 2 cycles (IDLE, WAIT), 0 in DONE; stall_count=2.
- Hazard only: hazard=1 for 1 cycle -> pc_freeze=if_freeze=1, id_flush=1, if_flush=0, stage_freeze=0; stall_count +1.
- Branch during stall: mem_w_en=1 and branch_taken=1 together, MEM_LATENCY=3 -> if_flush=id_flush=0 for 2 cycles, then if_flush=id_flush=1 in DONE; pc_freeze=0 in DONE.
- Branch plus hazard, no memory access: pc_freeze=0, if_freeze=0, if_flush=1, id_flush=1.
- Boundaries:
  - MEM_LATENCY=1 -> mem_access never stalls.
  - MEM_LATENCY=2 -> exactly 1 stall cycle.
  - STALL_CNT_W=4 with 20 hazard cycles -> stall_count holds at 15.
  - rst asserted in WAIT -> next cycle IDLE, outputs 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges hazard, taken-branch
// and fixed-latency memory wait into per-stage freeze/flush controls.
module pipeline_ctrl #(
  parameter int MEM_LATENCY = 3,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hazard,
  input  logic                   branch_taken,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  output logic                   pc_freeze,
  output logic                   if_freeze,
  output logic                   if_flush,
  output logic                   id_flush,
  output logic                   stage_freeze,
  output logic                   mem_busy,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam bit        MEM_STALLS = (MEM_LATENCY > 1);
  localparam bit        USE_WAIT   = (MEM_LATENCY >= 3);
  localparam logic [7:0] CNT_INIT  = USE_WAIT ? 8'(MEM_LATENCY - 3) : 8'd0;

  state_t     state, next_state;
  logic [7:0] cnt, cnt_next;
  logic       mem_access;
  logic       mem_stall;
  logic       freeze_req;

  assign mem_access = mem_r_en | mem_w_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      stall_count <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      if (pc_freeze && (stall_count != '1))
        stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end

  // The IDLE cycle itself is the first stall cycle, so WAIT covers the rest.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    mem_stall  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_access && MEM_STALLS) begin
          mem_stall = 1'b1;
          if (USE_WAIT) begin
            next_state = WAIT;
            cnt_next   = CNT_INIT;
          end else begin
            next_state = DONE;
          end
        end
      end
      WAIT: begin
        mem_stall = 1'b1;
        if (cnt == 8'd0)
          next_state = DONE;
        else
          cnt_next = cnt - 8'd1;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A taken branch beats a hazard; a memory stall beats both.
  assign freeze_req   = mem_stall | (hazard & ~branch_taken);
  assign pc_freeze    = ~rst & freeze_req;
  assign if_freeze    = ~rst & freeze_req;
  assign if_flush     = ~rst & branch_taken & ~mem_stall;
  assign id_flush     = ~rst & (branch_taken | hazard) & ~mem_stall;
  assign stage_freeze = ~rst & mem_stall;
  assign mem_busy     = ~rst & mem_stall;

endmodule
